// File: rtl/score_keeper_ctrl.sv
// Score keeper: saturating score, session high score, and an iterative
// binary-to-BCD converter that alternates score/high score while game_over is high.
module score_keeper_ctrl #(
  parameter int MAX_SCORE  = 99,
  parameter int ALT_CYCLES = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       game_rst,
  input  logic       eat,
  input  logic       game_over,
  output logic [7:0] score,
  output logic [7:0] high_score,
  output logic [7:0] bcd,
  output logic       show_high,
  output logic       bcd_valid,
  output logic       conv_busy
);

  localparam int TW = (ALT_CYCLES > 2) ? $clog2(ALT_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  logic [7:0]    score_reg, high_reg;
  logic [TW-1:0] timer_reg;
  logic          sel_reg;
  logic          force_reg, force_next;
  state_t        state_reg, state_next;
  logic [7:0]    bin_reg, bin_next;
  logic [7:0]    acc_reg, acc_next;
  logic [2:0]    cnt_reg, cnt_next;
  logic          sel_l_reg, sel_l_next;
  logic [7:0]    last_src_reg, last_src_next;
  logic [7:0]    src_l_reg, src_l_next;
  logic [7:0]    bcd_reg, bcd_next;
  logic          show_high_reg, show_high_next;
  logic          bcd_valid_reg, bcd_valid_next;
  logic [7:0]    src;
  logic [7:0]    acc_adj;

  // Score, high score and display-select timer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      score_reg <= '0;
      high_reg  <= '0;
      timer_reg <= '0;
      sel_reg   <= 1'b0;
    end else begin
      if (game_rst)
        score_reg <= '0;
      else if (!game_over && eat && (score_reg < 8'(MAX_SCORE)))
        score_reg <= score_reg + 8'd1;

      if (score_reg > high_reg)
        high_reg <= score_reg;

      if (!game_over) begin
        timer_reg <= '0;
        sel_reg   <= 1'b0;
      end else if (timer_reg == TW'(ALT_CYCLES - 1)) begin
        timer_reg <= '0;
        sel_reg   <= ~sel_reg;
      end else begin
        timer_reg <= timer_reg + TW'(1);
      end
    end
  end

  assign src = sel_reg ? high_reg : score_reg;

  // Shift-add-3 correction, one per BCD digit
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_adj
      assign acc_adj[gi*4 +: 4] = (acc_reg[gi*4 +: 4] >= 4'd5) ?
                                  acc_reg[gi*4 +: 4] + 4'd3 : acc_reg[gi*4 +: 4];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      force_reg     <= 1'b1;
      bin_reg       <= '0;
      acc_reg       <= '0;
      cnt_reg       <= '0;
      sel_l_reg     <= 1'b0;
      last_src_reg  <= '0;
      src_l_reg     <= '0;
      bcd_reg       <= '0;
      show_high_reg <= 1'b0;
      bcd_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      force_reg     <= force_next;
      bin_reg       <= bin_next;
      acc_reg       <= acc_next;
      cnt_reg       <= cnt_next;
      sel_l_reg     <= sel_l_next;
      last_src_reg  <= last_src_next;
      src_l_reg     <= src_l_next;
      bcd_reg       <= bcd_next;
      show_high_reg <= show_high_next;
      bcd_valid_reg <= bcd_valid_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    force_next     = force_reg;
    bin_next       = bin_reg;
    acc_next       = acc_reg;
    cnt_next       = cnt_reg;
    sel_l_next     = sel_l_reg;
    last_src_next  = last_src_reg;
    src_l_next     = src_l_reg;
    bcd_next       = bcd_reg;
    show_high_next = show_high_reg;
    bcd_valid_next = bcd_valid_reg;
    case (state_reg)
      IDLE: begin
        if (force_reg || (src != last_src_reg)) begin
          bin_next       = src;
          src_l_next     = src;
          sel_l_next     = sel_reg;
          acc_next       = '0;
          cnt_next       = '0;
          force_next     = 1'b0;
          bcd_valid_next = 1'b0;
          state_next     = SHIFT;
        end
      end
      SHIFT: begin
        acc_next = {acc_adj[6:0], bin_reg[7]};
        bin_next = {bin_reg[6:0], 1'b0};
        cnt_next = cnt_reg + 3'd1;
        if (cnt_reg == 3'd7)
          state_next = DONE;
      end
      DONE: begin
        // Result is published atomically with the select it belongs to
        bcd_next       = acc_reg;
        show_high_next = sel_l_reg;
        last_src_next  = src_l_reg;
        bcd_valid_next = 1'b1;
        state_next     = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign score      = score_reg;
  assign high_score = high_reg;
  assign bcd        = bcd_reg;
  assign show_high  = show_high_reg;
  assign bcd_valid  = bcd_valid_reg;
  assign conv_busy  = (state_reg != IDLE);

endmodule

// File: tb/tb_score_keeper_ctrl.sv
// Directed bench for score_keeper_ctrl with hand-computed expected values.
module tb_score_keeper_ctrl;

  logic       clk = 1'b0;
  logic       rst, game_rst, eat, game_over;
  logic [7:0] score, high_score, bcd;
  logic       show_high, bcd_valid, conv_busy;

  int checks = 0;
  int errors = 0;

  score_keeper_ctrl #(.MAX_SCORE(99), .ALT_CYCLES(20)) dut (
    .clk(clk), .rst(rst), .game_rst(game_rst), .eat(eat), .game_over(game_over),
    .score(score), .high_score(high_score), .bcd(bcd), .show_high(show_high),
    .bcd_valid(bcd_valid), .conv_busy(conv_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [7:0] prev_bcd;
  logic       past_ok;

  initial begin
    rst = 1'b1; game_rst = 1'b0; eat = 1'b0; game_over = 1'b0;
    tick(2);
    check("rst_score", score, 0);
    check("rst_high", high_score, 0);
    check("rst_bcd", bcd, 8'h00);
    check("rst_valid", bcd_valid, 0);
    check("rst_busy", conv_busy, 0);

    // 1: first conversion after reset release
    rst = 1'b0;
    tick(9);
    check("t1_valid_e9", bcd_valid, 0);
    check("t1_busy_e9", conv_busy, 1);
    tick(1);
    check("t1_valid_e10", bcd_valid, 1);
    check("t1_bcd", bcd, 8'h00);
    check("t1_show_high", show_high, 0);
    check("t1_busy_e10", conv_busy, 0);

    // 2: 37 spaced eats
    for (int i = 0; i < 37; i++) begin
      eat = 1'b1; tick(1); eat = 1'b0; tick(11);
    end
    check("t2_score", score, 37);
    check("t2_high", high_score, 37);
    check("t2_bcd", bcd, 8'h37);
    check("t2_valid", bcd_valid, 1);

    // 3: saturation at 99
    eat = 1'b1; tick(61); eat = 1'b0; tick(25);
    check("t3_score98", score, 98);
    check("t3_bcd98", bcd, 8'h98);
    for (int i = 0; i < 3; i++) begin
      eat = 1'b1; tick(1); eat = 1'b0; tick(11);
    end
    tick(10);
    check("t3_score_sat", score, 99);
    check("t3_high_sat", high_score, 99);
    check("t3_bcd99", bcd, 8'h99);

    // 4: alternating display during game over
    rst = 1'b1; tick(1); rst = 1'b0;
    eat = 1'b1; tick(45); eat = 1'b0; tick(25);
    check("t4_score45", score, 45);
    check("t4_high45", high_score, 45);
    check("t4_bcd45", bcd, 8'h45);
    game_rst = 1'b1; tick(1); game_rst = 1'b0;
    check("t4_game_rst_score", score, 0);
    check("t4_game_rst_high", high_score, 45);
    eat = 1'b1; tick(12); eat = 1'b0; tick(25);
    check("t4_bcd12", bcd, 8'h12);
    game_over = 1'b1;
    tick(19);
    check("t4_e19_show", show_high, 0);
    check("t4_e19_bcd", bcd, 8'h12);
    tick(10);
    check("t4_e29_bcd", bcd, 8'h12);
    tick(1);
    check("t4_e30_bcd", bcd, 8'h45);
    check("t4_e30_show", show_high, 1);
    check("t4_e30_valid", bcd_valid, 1);
    tick(19);
    check("t4_e49_bcd", bcd, 8'h45);
    tick(1);
    check("t4_e50_bcd", bcd, 8'h12);
    check("t4_e50_show", show_high, 0);
    eat = 1'b1; tick(1); eat = 1'b0;
    check("t4_eat_ignored", score, 12);
    tick(14);
    game_over = 1'b0;
    tick(5);
    check("t4_e70_bcd", bcd, 8'h45);
    check("t4_e70_show", show_high, 1);
    tick(15);
    check("t4_e85_bcd", bcd, 8'h12);
    check("t4_e85_show", show_high, 0);

    // 5: eats while converter busy; every published bcd is some past score
    prev_bcd = bcd;
    for (int c = 0; c < 40; c++) begin
      eat = (c == 0 || c == 3 || c == 4 || c == 5);
      tick(1);
      if (bcd != prev_bcd) begin
        past_ok = (bcd >= 8'h12 && bcd <= 8'h16);
        check("t5_bcd_past", past_ok, 1);
        prev_bcd = bcd;
      end
    end
    eat = 1'b0;
    check("t5_score", score, 16);
    check("t5_bcd", bcd, 8'h16);

    // 6: async reset mid-SHIFT
    eat = 1'b1; tick(1); eat = 1'b0;
    tick(2);
    check("t6_busy", conv_busy, 1);
    rst = 1'b1;
    #1;
    check("t6_rst_score", score, 0);
    check("t6_rst_high", high_score, 0);
    check("t6_rst_bcd", bcd, 8'h00);
    check("t6_rst_busy", conv_busy, 0);
    check("t6_rst_valid", bcd_valid, 0);
    check("t6_rst_show", show_high, 0);
    @(negedge clk);
    rst = 1'b0;
    tick(1);
    check("t6_restart_busy", conv_busy, 1);
    tick(9);
    check("t6_restart_valid", bcd_valid, 1);
    check("t6_restart_bcd", bcd, 8'h00);
    eat = 1'b1; tick(1); eat = 1'b0;
    check("t6_score1", score, 1);
    check("t6_high_lag", high_score, 0);
    tick(1);
    check("t6_high1", high_score, 1);
    game_rst = 1'b1; eat = 1'b1; tick(1); game_rst = 1'b0; eat = 1'b0;
    check("t6_rst_eat_score", score, 0);
    check("t6_rst_eat_high", high_score, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
